sprite_renderer: RTL and testbench
==================================

// Module: sprite_renderer
// PURPOSE
//  Pixel-stream consumer of the 32x16 1-bpp sprite frame ROMs (4 frames: 0/1 stand, 2/3 walk).
//  Takes the VGA scan position, drives the ROM frame select and row address, and produces a
//  registered per-pixel "sprite on" flag for the colour mixer.
//  Also runs the animation FSM and latches sprite position once per video frame, so the sprite does not tear mid-frame.
// PARAMETERS
//  COORD_W   10  width of pixel/sprite coordinates
//  ANIM_DIV  8   frame_tick count between walk-frame toggles (>=1)
// PORTS
//  clk          in   1        pixel clock
//  rst_n        in   1        asynchronous, active-low reset
//  frame_tick   in   1        1-cycle pulse at start of vertical blank
//  pix_x        in   COORD_W  current scan column
//  pix_y        in   COORD_W  current scan row
//  video_on     in   1        scan position is in the visible area
//  spr_x        in   COORD_W  requested sprite left edge (sampled on frame_tick)
//  spr_y        in   COORD_W  requested sprite top edge (sampled on frame_tick)
//  moving       in   1        player walking (sampled on frame_tick)
//  facing_left  in   1        mirror request (used only with SPRITE_MIRROR_EN)
//  rom_sel      out  2        frame ROM select, 0..3
//  rom_addr     out  4        ROM row address
//  rom_data     in   32       row data from selected ROM; bit 31 = leftmost pixel
//  spr_on       out  1        sprite pixel lit, aligned 2 cycles after pix_x/pix_y
//  spr_valid    out  1        video_on delayed 2 cycles
// BEHAVIOUR
//  Reset: rom_sel=0, rom_addr=0, spr_on=0, spr_valid=0; shadow spr_x/spr_y=0; FSM=STAND; div counter=0.
//  Shadow regs: on frame_tick, shadow_x<=spr_x, shadow_y<=spr_y, moving_q<=moving. They are never updated at other times.
//  Stage 1 (registered): dx=pix_x-shadow_x, dy=pix_y-shadow_y, computed COORD_W+1 wide.
//   hit = video_on & dx in [0,31] & dy in [0,15]. Negative values (MSB set) are not hits.
//   rom_addr<=dy[3:0] when hit, else 0; col_q<=dx[4:0]; hit_q<=hit; von_q<=video_on.
//  Stage 2 (registered): spr_on<=hit_q & rom_data[31-col_q]; spr_valid<=von_q.
//  Total latency from pix_x/pix_y to spr_on is 2 clocks.
//  Sprite overlapping the right/bottom screen edge is clipped naturally. Coordinate wrap is not a hit.
//  Animation FSM, advanced only on frame_tick:
//   STAND : rom_sel=0; if moving -> WALK_A (div counter cleared)
//   WALK_A: rom_sel=2; !moving -> STAND; else when div reaches ANIM_DIV-1 -> WALK_B, div=0
//   WALK_B: rom_sel=3; !moving -> STAND; else when div reaches ANIM_DIV-1 -> WALK_A, div=0
//   Within a walk state, div increments on each frame_tick that causes no transition.
//   rom_sel changes only in the cycle after frame_tick; rom_sel=1 is reserved (blink frame, unused).
//  Simultaneous frame_tick and visible pixel cannot occur; if it does, the pixel uses the old shadow values.
//  Reset mid-frame: the outputs clear immediately; rendering resumes from the next frame_tick with shadow position (0,0).
// CONFIGURATION
//  SPRITE_MIRROR_EN defined: facing_left is sampled on frame_tick into face_q.
//   When face_q=1, stage 2 uses rom_data[col_q] (horizontal flip).
//  Not defined: facing_left is ignored, face_q is absent, and the sprite is always drawn unmirrored.
// STRUCTURE
//  sprite_pkg holds:
//   SPR_W=32, SPR_H=16, SPR_FRAMES=4
//   typedef enum logic [1:0] {STAND, WALK_A, WALK_B} anim_state_t
//   frame index constants FR_STAND=0, FR_WALK_A=2, FR_WALK_B=3
//  Sub-module sprite_anim_fsm holds the FSM plus div counter.
//   Inputs: clk, rst_n, frame_tick, moving_q. Output: rom_sel.
//  The datapath pipeline stays in sprite_renderer.
// TESTING
//  1. Reset, then frame_tick with spr_x=100, spr_y=50, scan pix(100..131, 50).
//     -> rom_addr=0 and spr_on=0 for every pixel in that row.
//  2. Same position, scan row 53 with frame 0 ROM model.
//     -> spr_on=1 exactly at x=111..118, 2 cycles after each pixel; spr_valid follows video_on.
//  3. moving=1, ANIM_DIV=2, 6 frame_ticks.
//     -> rom_sel sequence 2,2,3,3,2,2; then moving=0 + tick -> rom_sel=0.
//  4. spr_x=620 on 640-wide scan.
//     -> only columns 0..19 are drawn; pix_x wrap back to 0 gives no spurious hit.
//  5. Assert rst_n low mid-row while spr_on=1.
//     -> spr_on, spr_valid, rom_sel drop to 0 asynchronously; no output until the next frame_tick.
//  6. SPRITE_MIRROR_EN defined, facing_left=1, row 7 of frame 2.
//     -> lit columns equal the bit-reversed row; without the macro, the unmirrored row.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared constants and types for the sprite renderer.
//   SPR_W / SPR_H  : sprite bitmap size in pixels (one 32-bit ROM word per row)
//   SPR_FRAMES     : number of frame ROMs behind rom_sel
//   anim_state_t   : animation FSM states
//   FR_*           : frame ROM indices used by each animation state
//   frame_of()     : maps an animation state to its frame ROM index
package sprite_pkg;

    localparam int SPR_W      = 32;
    localparam int SPR_H      = 16;
    localparam int SPR_FRAMES = 4;

    typedef enum logic [1:0] {
        STAND,
        WALK_A,
        WALK_B
    } anim_state_t;

    localparam logic [1:0] FR_STAND  = 2'd0;
    localparam logic [1:0] FR_WALK_A = 2'd2;
    localparam logic [1:0] FR_WALK_B = 2'd3;

    function automatic logic [1:0] frame_of(input anim_state_t s);
        logic [1:0] fr;
        case (s)
            WALK_A:  fr = FR_WALK_A;
            WALK_B:  fr = FR_WALK_B;
            default: fr = FR_STAND;
        endcase
        return fr;
    endfunction

endpackage

// File: rtl/sprite_anim_fsm.sv
// Animation sequencer: picks which sprite frame ROM is shown.
// Advances only on frame_tick, so the frame never changes mid-picture.
//
//   state  | meaning
//   -------+-----------------------------------------------
//   STAND  | standing still, frame 0
//   WALK_A | walking, first stride frame (2)
//   WALK_B | walking, second stride frame (3)
//
// Ports:
//   clk, rst_n   pixel clock, async active-low reset
//   frame_tick   start-of-vblank pulse, the only time the FSM moves
//   moving_q     walking request, valid whenever frame_tick is high
//   rom_sel      frame ROM select (0, 2 or 3; 1 is never produced)
module sprite_anim_fsm
    import sprite_pkg::*;
#(
    parameter int ANIM_DIV = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       moving_q,
    output logic [1:0] rom_sel
);

    localparam int DIV_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(ANIM_DIV - 1);

    anim_state_t      state, state_nxt;
    logic [DIV_W-1:0] div, div_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= STAND;
            div   <= '0;
        end else begin
            state <= state_nxt;
            div   <= div_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        div_nxt   = div;
        rom_sel   = frame_of(state);
        if (frame_tick) begin
            case (state)
                STAND: begin
                    if (moving_q) begin
                        state_nxt = WALK_A;
                        div_nxt   = '0;
                    end
                end
                WALK_A, WALK_B: begin
                    if (!moving_q) begin
                        state_nxt = STAND;
                        div_nxt   = '0;
                    end else if (div == DIV_LAST) begin
                        state_nxt = (state == WALK_A) ? WALK_B : WALK_A;
                        div_nxt   = '0;
                    end else begin
                        div_nxt = div + 1'b1;
                    end
                end
                default: begin
                    state_nxt = STAND;
                    div_nxt   = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/sprite_renderer.sv
// Sprite renderer: turns the VGA scan position into a per-pixel "sprite on"
// flag using the 32x16 1-bpp frame ROMs. Two-stage pipeline, so spr_on and
// spr_valid line up two clocks after pix_x/pix_y/video_on.
// Sprite position, walk request (and facing, when mirroring is built in)
// are latched only on frame_tick so the sprite never tears mid-frame.
//
// Build option: define SPRITE_MIRROR_EN to enable horizontal flip driven by
// facing_left; without it facing_left is ignored.
//
// Ports:
//   clk, rst_n            pixel clock, async active-low reset
//   frame_tick            start-of-vblank pulse
//   pix_x, pix_y          scan position
//   video_on              scan position is visible
//   spr_x, spr_y, moving  sprite position and walk request (sampled on tick)
//   facing_left           mirror request (SPRITE_MIRROR_EN only)
//   rom_sel, rom_addr     frame ROM select and row address
//   rom_data              row from the selected ROM, bit 31 = leftmost pixel
//   spr_on, spr_valid     sprite pixel lit / video_on, both 2 clocks late
module sprite_renderer
    import sprite_pkg::*;
#(
    parameter int COORD_W  = 10,
    parameter int ANIM_DIV = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_tick,
    input  logic [COORD_W-1:0] pix_x,
    input  logic [COORD_W-1:0] pix_y,
    input  logic               video_on,
    input  logic [COORD_W-1:0] spr_x,
    input  logic [COORD_W-1:0] spr_y,
    input  logic               moving,
    input  logic               facing_left,
    output logic [1:0]         rom_sel,
    output logic [3:0]         rom_addr,
    input  logic [31:0]        rom_data,
    output logic               spr_on,
    output logic               spr_valid
);

    localparam int COL_W = $clog2(SPR_W);
    localparam int ROW_W = $clog2(SPR_H);

    logic [COORD_W-1:0] shadow_x, shadow_y;
    logic               moving_q;
    logic               moving_now;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_x <= '0;
            shadow_y <= '0;
            moving_q <= 1'b0;
        end else if (frame_tick) begin
            shadow_x <= spr_x;
            shadow_y <= spr_y;
            moving_q <= moving;
        end
    end

    // The FSM only looks at this during frame_tick; feeding it the value
    // being latched lets a walk request take effect on the same vblank.
    assign moving_now = frame_tick ? moving : moving_q;

    sprite_anim_fsm #(
        .ANIM_DIV (ANIM_DIV)
    ) u_anim (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .moving_q   (moving_now),
        .rom_sel    (rom_sel)
    );

    // Stage 1: one extra bit on the subtraction keeps "left of / above the
    // sprite" (and coordinate wrap) as a negative result instead of a hit.
    logic [COORD_W:0]   dx, dy;
    logic               hit;
    logic [COL_W-1:0]   col_q;
    logic               hit_q;
    logic               von_q;

    assign dx  = {1'b0, pix_x} - {1'b0, shadow_x};
    assign dy  = {1'b0, pix_y} - {1'b0, shadow_y};
    assign hit = video_on
               & (dx[COORD_W:COL_W] == '0)
               & (dy[COORD_W:ROW_W] == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr <= '0;
            col_q    <= '0;
            hit_q    <= 1'b0;
            von_q    <= 1'b0;
        end else begin
            rom_addr <= hit ? dy[ROW_W-1:0] : '0;
            col_q    <= dx[COL_W-1:0];
            hit_q    <= hit;
            von_q    <= video_on;
        end
    end

    // Stage 2: ~col_q is 31-col_q, i.e. column 0 reads the MSB.
    logic pix_bit;

`ifdef SPRITE_MIRROR_EN
    logic face_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            face_q <= 1'b0;
        end else if (frame_tick) begin
            face_q <= facing_left;
        end
    end

    assign pix_bit = face_q ? rom_data[col_q] : rom_data[~col_q];
`else
    logic unused_facing;

    assign unused_facing = facing_left;
    assign pix_bit       = rom_data[~col_q];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spr_on    <= 1'b0;
            spr_valid <= 1'b0;
        end else begin
            spr_on    <= hit_q & pix_bit;
            spr_valid <= von_q;
        end
    end

endmodule

// File: tb/tb_sprite_renderer.sv
// Self-checking bench for sprite_renderer. Stimulus pushes the expected
// pixel result into a scoreboard queue; a monitor pops one entry every
// cycle the DUT presents spr_valid and checks value and 2-clock latency.
module tb_sprite_renderer;

    localparam int CW = 10;
    localparam int AD = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          frame_tick = 1'b0;
    logic          video_on = 1'b0;
    logic          moving = 1'b0;
    logic          facing_left = 1'b0;
    logic [CW-1:0] pix_x = '0, pix_y = '0, spr_x = '0, spr_y = '0;
    logic [1:0]    rom_sel;
    logic [3:0]    rom_addr;
    logic [31:0]   rom_data;
    logic          spr_on, spr_valid;

    logic [31:0] rom [4][16];
    assign rom_data = rom[rom_sel][rom_addr];

    always #5 clk = ~clk;

    sprite_renderer #(.COORD_W(CW), .ANIM_DIV(AD)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_tick  (frame_tick),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .video_on    (video_on),
        .spr_x       (spr_x),
        .spr_y       (spr_y),
        .moving      (moving),
        .facing_left (facing_left),
        .rom_sel     (rom_sel),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .spr_on      (spr_on),
        .spr_valid   (spr_valid)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int lit_cnt = 0;
    bit mon_en = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int x;
        int y;
        bit on;
        int c;
    } exp_t;
    exp_t sb[$];

    // Reference model state: what the sprite should look like this frame.
    int m_sx = 0, m_sy = 0, m_frame = 0, m_div = 0;
    bit m_face = 0;

    function automatic bit model_on(input int x, input int y);
        int c, r;
        logic [31:0] w;
        if (x < m_sx || x >= m_sx + 32 || y < m_sy || y >= m_sy + 16) return 1'b0;
        c = x - m_sx;
        r = y - m_sy;
        w = rom[m_frame][r];
`ifdef SPRITE_MIRROR_EN
        if (m_face) return w[c];
`endif
        return w[31 - c];
    endfunction

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d (t=%0t)", name, got, want, $time);
        end
    endtask

    always @(posedge clk) begin : monitor
        exp_t e;
        #1;
        if (mon_en && rst_n) begin
            total++;
            if (spr_valid) begin
                if (spr_on) lit_cnt++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL extra_valid got spr_valid=1 want no pending pixel (cyc=%0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    if (spr_on !== e.on || cyc - e.c != 2) begin
                        bad++;
                        $display("FAIL pixel(%0d,%0d) got on=%0d lat=%0d want on=%0d lat=2",
                                 e.x, e.y, spr_on, cyc - e.c, e.on);
                    end
                end
            end else if (spr_on !== 1'b0) begin
                bad++;
                $display("FAIL on_without_valid got spr_on=%0d want 0", spr_on);
            end
        end
    end

    task automatic px(input int x, input int y, input bit von, input bit push);
        @(negedge clk);
        pix_x    = x[CW-1:0];
        pix_y    = y[CW-1:0];
        video_on = von;
        if (von && push) sb.push_back('{x, y, model_on(x, y), cyc});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) px(0, 0, 1'b0, 1'b0);
    endtask

    task automatic tick(input int sx, input int sy, input bit mv, input bit fc);
        idle(3);
        @(negedge clk);
        video_on    = 1'b0;
        frame_tick  = 1'b1;
        spr_x       = sx[CW-1:0];
        spr_y       = sy[CW-1:0];
        moving      = mv;
        facing_left = fc;
        @(negedge clk);
        frame_tick = 1'b0;
        if (m_frame == 0) begin
            if (mv) begin m_frame = 2; m_div = 0; end
        end else if (!mv) begin
            m_frame = 0; m_div = 0;
        end else if (m_div == AD - 1) begin
            m_frame = (m_frame == 2) ? 3 : 2; m_div = 0;
        end else begin
            m_div++;
        end
        m_sx = sx; m_sy = sy; m_face = fc;
        check("rom_sel_after_tick", rom_sel, m_frame);
    endtask

    task automatic scan(input int y, input int x0, input int x1);
        for (int x = x0; x <= x1; x++) px(x, y, 1'b1, 1'b1);
        idle(3);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seq[6];
        int want_seq[6];
        int lit0;
        bit found;
        int sx, sy, y, xa, xb;

        want_seq = '{2, 2, 3, 3, 2, 2};
        for (int f = 0; f < 4; f++)
            for (int r = 0; r < 16; r++) rom[f][r] = $urandom;
        rom[0][0] = 32'h0000_0000;
        rom[0][3] = 32'h001F_E000;
        rom[2][3] = 32'hFFFF_FFFF;
        rom[3][3] = 32'hFFFF_FFFF;

        // reset state
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rom_sel", rom_sel, 0);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_spr_on", spr_on, 0);
        check("rst_spr_valid", spr_valid, 0);
        @(negedge clk) rst_n = 1'b1;

        // 1: top row of sprite, frame 0 row 0 is blank
        tick(100, 50, 1'b0, 1'b0);
        for (int x = 100; x <= 131; x++) begin
            px(x, 50, 1'b1, 1'b1);
            @(posedge clk); #1;
            check("t1_rom_addr", rom_addr, 0);
        end
        idle(3);

        // 2: row 53 -> lit at x 111..118, rom_addr follows the row
        lit0 = lit_cnt;
        for (int x = 96; x <= 135; x++) begin
            px(x, 53, 1'b1, 1'b1);
            @(posedge clk); #1;
            check("t2_rom_addr", rom_addr, (x >= 100 && x <= 131) ? 3 : 0);
        end
        for (int x = 96; x <= 135; x++) px(x, 53, x[0], 1'b1);
        idle(3);
        check("t2_lit_count", lit_cnt - lit0, 8 + 4);

        // 3: walk animation with ANIM_DIV=2
        for (int i = 0; i < 6; i++) begin
            tick(100, 50, 1'b1, 1'b0);
            seq[i] = rom_sel;
        end
        for (int i = 0; i < 6; i++) check("t3_walk_seq", seq[i], want_seq[i]);
        tick(100, 50, 1'b0, 1'b0);
        check("t3_stop", rom_sel, 0);

        // 4: right-edge clipping and pix_x wrap
        tick(620, 200, 1'b0, 1'b0);
        lit0 = lit_cnt;
        scan(203, 600, 639);
        scan(203, 0, 25);
        check("t4_edge_lit", lit_cnt - lit0, 8);
        scan(205, 600, 639);
        scan(205, 0, 25);

        // 5: reset mid-row while lit
        tick(100, 50, 1'b1, 1'b0);
        mon_en = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            px(105, 53, 1'b1, 1'b0);
            @(posedge clk); #1;
            if (spr_on === 1'b1) found = 1'b1;
        end
        check("t5_lit_before_reset", found, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_spr_on", spr_on, 0);
        check("t5_spr_valid", spr_valid, 0);
        check("t5_rom_sel", rom_sel, 0);
        check("t5_rom_addr", rom_addr, 0);
        @(negedge clk);
        video_on = 1'b0;
        sb.delete();
        m_sx = 0; m_sy = 0; m_frame = 0; m_div = 0; m_face = 0;
        idle(2);
        @(negedge clk) rst_n = 1'b1;
        mon_en = 1'b1;
        lit0 = lit_cnt;
        scan(53, 96, 135);
        check("t5_no_output_after_reset", lit_cnt - lit0, 0);
        check("t5_rom_sel_after", rom_sel, 0);

        // 6: row 7 of frame 2, facing left
        tick(300, 100, 1'b0, 1'b1);
        tick(300, 100, 1'b1, 1'b1);
        check("t6_frame", rom_sel, 2);
        scan(107, 296, 335);
        tick(300, 100, 1'b0, 1'b0);

        // randomized frames
        for (int n = 0; n < 20; n++) begin
            sx = $urandom_range(0, 639);
            sy = $urandom_range(0, 479);
            tick(sx, sy, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            for (int k = 0; k < 3; k++) begin
                y = sy + $urandom_range(0, 19) - 2;
                if (y < 0) y = 0;
                xa = (sx - 4 < 0) ? 0 : sx - 4;
                xb = (sx + 35 > 639) ? 639 : sx + 35;
                for (int x = xa; x <= xb; x++)
                    px(x, y, ($urandom_range(0, 7) != 0), 1'b1);
                idle(3);
            end
        end

        idle(4);
        check("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
